// File: rtl/updown_seq_decoder_pkg.sv
// Shared encodings for the up/down sequence decoder: FSM states, code-delta
// classes and the modulo-4 delta helper.
package updown_seq_decoder_pkg;

   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_TRACK = 2'd1;
   localparam logic [1:0] ST_ERROR = 2'd2;

   localparam logic [1:0] DLT_HOLD = 2'd0;
   localparam logic [1:0] DLT_UP   = 2'd1;
   localparam logic [1:0] DLT_ILL  = 2'd2;
   localparam logic [1:0] DLT_DN   = 2'd3;

   // Two-bit subtraction wraps naturally, giving (code - prev) mod 4.
   function automatic logic [1:0] code_delta(input logic [1:0] prev, input logic [1:0] code);
      return code - prev;
   endfunction

endpackage

// File: rtl/updown_seq_decoder_step_classify.sv
// Combinational classifier: compares the previous and current counter code
// and reports which kind of move the counter made.
module updown_step_classify
   import updown_seq_decoder_pkg::*;
(
   input  logic [1:0] prev,
   input  logic [1:0] code,
   output logic       up,
   output logic       dn,
   output logic       hold,
   output logic       ill
);

   logic [1:0] delta;

   assign delta = code_delta(prev, code);
   assign hold  = (delta == DLT_HOLD);
   assign up    = (delta == DLT_UP);
   assign ill   = (delta == DLT_ILL);
   assign dn    = (delta == DLT_DN);

endmodule

// File: rtl/updown_seq_decoder.sv
// Recovers direction, position and illegal-jump status from a 2-bit up/down
// counter stream, sampling on the falling clock edge.
// Optional direction filter: define UPDN_DEC_DIRFILT_EN.
module updown_seq_decoder
   import updown_seq_decoder_pkg::*;
#(
   parameter int POS_W      = 8,
   parameter bit ERR_STICKY = 1'b1
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic [1:0]              code,
   input  logic                    clr_err,
   output logic signed [POS_W-1:0] pos,
   output logic                    dir,
   output logic                    step,
   output logic                    err,
   output logic                    locked
);

   localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

   logic [1:0]       state_q, state_d;
   logic [1:0]       prev_q, prev_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic             dir_q, dir_d;
   logic             step_q, step_d;
   logic             err_q, err_d;
   logic             locked_q, locked_d;
   logic             up, dn, hold, ill;

`ifdef UPDN_DEC_DIRFILT_EN
   logic             pend_dir_q, pend_dir_d;
   logic             pend_cnt_q, pend_cnt_d;
`endif

   updown_step_classify u_classify (
      .prev (prev_q),
      .code (code),
      .up   (up),
      .dn   (dn),
      .hold (hold),
      .ill  (ill)
   );

   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_d  = state_q;
      prev_d   = prev_q;
      pos_d    = pos_q;
      dir_d    = dir_q;
      step_d   = 1'b0;
      err_d    = err_q;
      locked_d = locked_q;
`ifdef UPDN_DEC_DIRFILT_EN
      pend_dir_d = pend_dir_q;
      pend_cnt_d = pend_cnt_q;
`endif
      if (en) begin
         prev_d = code;
         case (state_q)
            ST_INIT: begin
               state_d  = ST_TRACK;
               locked_d = 1'b1;
`ifdef UPDN_DEC_DIRFILT_EN
               pend_dir_d = 1'b0;
               pend_cnt_d = 1'b0;
`endif
            end
            ST_TRACK: begin
               // An illegal jump outranks a simultaneous clr_err.
               if (ill) begin
                  state_d  = ST_ERROR;
                  err_d    = 1'b1;
                  locked_d = 1'b0;
               end else if (!hold) begin
                  step_d = 1'b1;
                  pos_d  = dn ? pos_q - POS_ONE : pos_q + POS_ONE;
`ifdef UPDN_DEC_DIRFILT_EN
                  if (up == dir_q) begin
                     pend_cnt_d = 1'b0;
                  end else if (pend_cnt_q && (pend_dir_q == up)) begin
                     dir_d      = up;
                     pend_cnt_d = 1'b0;
                  end else begin
                     pend_dir_d = up;
                     pend_cnt_d = 1'b1;
                  end
`else
                  dir_d = up;
`endif
               end
            end
            ST_ERROR: begin
               locked_d = 1'b0;
               if (clr_err || !ERR_STICKY) begin
                  state_d = ST_INIT;
                  err_d   = 1'b0;
               end
            end
            default: begin
               state_d  = ST_INIT;
               locked_d = 1'b0;
               err_d    = 1'b0;
            end
         endcase
      end
   end

   // NOTE: async reset clears every flop at once; non-blocking keeps updates race-free.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_INIT;
         prev_q   <= 2'b00;
         pos_q    <= '0;
         dir_q    <= 1'b0;
         step_q   <= 1'b0;
         err_q    <= 1'b0;
         locked_q <= 1'b0;
`ifdef UPDN_DEC_DIRFILT_EN
         pend_dir_q <= 1'b0;
         pend_cnt_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         pos_q    <= pos_d;
         dir_q    <= dir_d;
         step_q   <= step_d;
         err_q    <= err_d;
         locked_q <= locked_d;
`ifdef UPDN_DEC_DIRFILT_EN
         pend_dir_q <= pend_dir_d;
         pend_cnt_q <= pend_cnt_d;
`endif
      end
   end

   assign pos    = pos_q;
   assign dir    = dir_q;
   assign step   = step_q;
   assign err    = err_q;
   assign locked = locked_q;

endmodule

// File: tb/tb_updown_seq_decoder.sv
// Scoreboard bench for updown_seq_decoder (POS_W = 4, sticky errors, default
// build): directed samples push expected outputs, a monitor checks each edge.
module tb_updown_seq_decoder;

   typedef struct {
      logic [3:0] pos;
      logic       dir;
      logic       step;
      logic       err;
      logic       locked;
      string      tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic [1:0] code = 2'd2;
   logic       clr_err = 1'b0;
   logic [3:0] pos;
   logic       dir, step, err, locked;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   updown_seq_decoder #(.POS_W(4), .ERR_STICKY(1'b1)) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .code    (code),
      .clr_err (clr_err),
      .pos     (pos),
      .dir     (dir),
      .step    (step),
      .err     (err),
      .locked  (locked)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      check({tag, ".pos"},    {28'd0, pos}, 32'd0);
      check({tag, ".dir"},    {31'd0, dir}, 32'd0);
      check({tag, ".step"},   {31'd0, step}, 32'd0);
      check({tag, ".err"},    {31'd0, err}, 32'd0);
      check({tag, ".locked"}, {31'd0, locked}, 32'd0);
   endtask

   // Drive one sample after the rising edge; the DUT captures it on the next falling edge.
   task automatic sample(input logic [1:0] c, input logic e, input logic clr,
                         input logic [3:0] p, input logic d, input logic s,
                         input logic er, input logic lk, input string tag);
      exp_t x;
      @(posedge clk);
      code    = c;
      en      = e;
      clr_err = clr;
      x.pos = p; x.dir = d; x.step = s; x.err = er; x.locked = lk; x.tag = tag;
      sb_q.push_back(x);
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk);
      en      = 1'b0;
      clr_err = 1'b0;
      reset   = 1'b1;
      #1 chk_zero(tag);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(negedge clk);
         #1;
         if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check({x.tag, ".pos"},    {28'd0, pos},    {28'd0, x.pos});
            check({x.tag, ".dir"},    {31'd0, dir},    {31'd0, x.dir});
            check({x.tag, ".step"},   {31'd0, step},   {31'd0, x.step});
            check({x.tag, ".err"},    {31'd0, err},    {31'd0, x.err});
            check({x.tag, ".locked"}, {31'd0, locked}, {31'd0, x.locked});
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "bench timed out");
   end

   initial begin : stimulus
      // Power-on reset with code = 2 present.
      #3 chk_zero("por");
      @(posedge clk);
      #1 reset = 1'b0;

      //       code  en clr pos  dir step err lock
      sample(2'd2, 1, 0, 4'd0, 0, 0, 0, 1, "lock2");
      sample(2'd3, 1, 0, 4'd1, 1, 1, 0, 1, "up_3");
      sample(2'd0, 1, 0, 4'd2, 1, 1, 0, 1, "up_0");
      sample(2'd1, 1, 0, 4'd3, 1, 1, 0, 1, "up_1");

      // Up x3 then down x2, then a hold.
      do_reset("rst_t2");
      sample(2'd0, 1, 0, 4'd0, 0, 0, 0, 1, "t2_lock");
      sample(2'd1, 1, 0, 4'd1, 1, 1, 0, 1, "t2_u1");
      sample(2'd2, 1, 0, 4'd2, 1, 1, 0, 1, "t2_u2");
      sample(2'd3, 1, 0, 4'd3, 1, 1, 0, 1, "t2_u3");
      sample(2'd2, 1, 0, 4'd2, 0, 1, 0, 1, "t2_d1");
      sample(2'd1, 1, 0, 4'd1, 0, 1, 0, 1, "t2_d2");
      sample(2'd1, 1, 0, 4'd1, 0, 0, 0, 1, "t2_hold");

      // Illegal jump, stray codes, clear, relock, clr_err corner cases.
      do_reset("rst_t3");
      sample(2'd0, 1, 0, 4'd1 - 4'd1, 0, 0, 0, 1, "t3_lock");
      sample(2'd1, 1, 0, 4'd1, 1, 1, 0, 1, "t3_up");
      sample(2'd3, 1, 0, 4'd1, 1, 0, 1, 0, "t3_ill");
      sample(2'd0, 1, 0, 4'd1, 1, 0, 1, 0, "t3_stray0");
      sample(2'd2, 1, 0, 4'd1, 1, 0, 1, 0, "t3_stray2");
      sample(2'd2, 1, 1, 4'd1, 1, 0, 0, 0, "t3_clr");
      sample(2'd3, 1, 0, 4'd1, 1, 0, 0, 1, "t3_relock");
      sample(2'd0, 1, 0, 4'd2, 1, 1, 0, 1, "t3_up2");
      sample(2'd0, 1, 1, 4'd2, 1, 0, 0, 1, "t3_clr_track");
      sample(2'd2, 1, 1, 4'd2, 1, 0, 1, 0, "t3_ill_vs_clr");
      sample(2'd2, 1, 1, 4'd2, 1, 0, 0, 0, "t3_clr2");

      // Wrap with POS_W = 4: 17 up then 17 down steps from 0.
      do_reset("rst_t4u");
      sample(2'd0, 1, 0, 4'd0, 0, 0, 0, 1, "t4u_lock");
      for (int i = 0; i < 17; i++)
         sample(2'(i + 1), 1, 0, 4'(i + 1), 1, 1, 0, 1, "t4_up");
      do_reset("rst_t4d");
      sample(2'd0, 1, 0, 4'd0, 0, 0, 0, 1, "t4d_lock");
      for (int i = 0; i < 17; i++)
         sample(2'(-(i + 1)), 1, 0, 4'(-(i + 1)), 0, 1, 0, 1, "t4_dn");

      // en low while code moves, then an enabled sample sees delta = 2.
      do_reset("rst_t5");
      sample(2'd3, 1, 0, 4'd0, 0, 0, 0, 1, "t5_lock");
      sample(2'd0, 1, 0, 4'd1, 1, 1, 0, 1, "t5_up");
      sample(2'd0, 0, 0, 4'd1, 1, 0, 0, 1, "t5_en0_a");
      sample(2'd1, 0, 0, 4'd1, 1, 0, 0, 1, "t5_en0_b");
      sample(2'd2, 0, 0, 4'd1, 1, 0, 0, 1, "t5_en0_c");
      sample(2'd2, 1, 0, 4'd1, 1, 0, 1, 0, "t5_ill");

      // Async reset pulse between edges, mid-stream with err set.
      do_reset("rst_t6");
      sample(2'd0, 1, 0, 4'd0, 0, 0, 0, 1, "t6_lock");
      sample(2'd1, 1, 0, 4'd1, 1, 1, 0, 1, "t6_up");
      sample(2'd3, 1, 0, 4'd1, 1, 0, 1, 0, "t6_ill");
      @(posedge clk);
      en = 1'b0;
      #2 reset = 1'b1;
      #1 chk_zero("t6_async");
      #1 reset = 1'b0;
      sample(2'd1, 1, 0, 4'd0, 0, 0, 0, 1, "t6_relock");
      sample(2'd2, 1, 0, 4'd1, 1, 1, 0, 1, "t6_up2");

      @(posedge clk);
      en = 1'b0;
      repeat (3) @(posedge clk);
      check("sb_drained", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
